mul_seq_16bits: RTL and testbench

Sequential 16x16 shift-add multiplier controller built around one shared `comp_adder_16bits` instance. It latches two operands on a start pulse and sequences the adder through one partial-product step per cycle for 16 cycles. It then presents a 32-bit product with a one-cycle done pulse. It is the multiply unit for the riskHDL execute stage and reuses the existing add/subtract datapath instead of a combinational array multiplier.

---
 rtl/mul_seq_16bits.sv | 126 ++++++++++++
 tb/tb_mul_seq_16bits.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_16bits.sv
// Sequential 16x16 shift-add multiplier that reuses one comp_adder_16bits, one step per cycle.
// Define MUL_SEQ_SIGNED_EN to add the sign_op port and two's-complement mode.

module comp_adder_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic        sign,
    input  logic        comp_e,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] b_eff;
    logic        c0;

    // With comp_e set, sign selects a + b or a - b (invert b, carry-in of one)
    always_comb begin
        b_eff = comp_e ? (b ^ {16{sign}}) : b;
        c0    = comp_e ? sign : cin;
        {cout, s} = {1'b0, a} + {1'b0, b_eff} + {16'b0, c0};
    end
endmodule

module mul_seq_16bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
`ifdef MUL_SEQ_SIGNED_EN
    input  logic        sign_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] acc_hi, acc_lo, mcand;
    logic [3:0]  cnt;
    logic        sgn;
    logic        load, step, last;
    logic [15:0] add_b, b_eff, sum;
    logic        add_sign, cout, ext;
    logic [31:0] shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (cnt == 4'd15) state_next = DONE;
            end
            DONE: begin
                load       = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign step = (state == RUN);
    assign last = step && (cnt == 4'd15);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // The multiplier bit 15 carries negative weight in signed mode, so the last step subtracts
    assign add_b    = acc_lo[0] ? mcand : 16'h0000;
    assign add_sign = sgn & acc_lo[0] & (cnt == 4'd15);
    assign b_eff    = add_b ^ {16{add_sign}};

    comp_adder_16bits u_adder (
        .a      (acc_hi),
        .b      (add_b),
        .cin    (1'b0),
        .sign   (add_sign),
        .comp_e (1'b1),
        .s      (sum),
        .cout   (cout)
    );

    // 17th sum bit: carry for unsigned, true sign of the 17-bit result for signed
    assign ext     = sgn ? (acc_hi[15] ^ b_eff[15] ^ cout) : cout;
    assign shifted = {ext, sum, acc_lo[15:1]};

`ifndef MUL_SEQ_SIGNED_EN
    assign sgn = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hi  <= 16'h0000;
            acc_lo  <= 16'h0000;
            mcand   <= 16'h0000;
            cnt     <= 4'd0;
            product <= 32'h0000_0000;
`ifdef MUL_SEQ_SIGNED_EN
            sgn     <= 1'b0;
`endif
        end else if (load) begin
            acc_hi <= 16'h0000;
            acc_lo <= op_b;
            mcand  <= op_a;
            cnt    <= 4'd0;
`ifdef MUL_SEQ_SIGNED_EN
            sgn    <= sign_op;
`endif
        end else if (step) begin
            {acc_hi, acc_lo} <= shifted;
            cnt              <= cnt + 4'd1;
            if (last) product <= shifted;
        end
    end
endmodule

// File: tb/tb_mul_seq_16bits.sv
// Directed self-checking bench for mul_seq_16bits; signed vectors run only when MUL_SEQ_SIGNED_EN is defined.

module tb_mul_seq_16bits;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
`ifdef MUL_SEQ_SIGNED_EN
    logic        sign_op;
`endif
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks;
    int n_fail;

    mul_seq_16bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
`ifdef MUL_SEQ_SIGNED_EN
        .sign_op (sign_op),
`endif
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start pulse from a falling edge; returns at the falling edge after acceptance
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cnt, output int overlap);
        cycles   = 0;
        busy_cnt = 0;
        overlap  = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        if (busy && done) overlap++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 16'h0;
        op_b  = 16'h0;
`ifdef MUL_SEQ_SIGNED_EN
        sign_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (product !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_product: got %h expected 00000000", product); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, bc, ov;
        start_op(16'h0003, 16'h0005);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (cyc !== 16) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 16", cyc); end
        n_checks++;
        if (bc !== 16) begin n_fail++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 16", bc); end
        n_checks++;
        if (ov !== 0) begin n_fail++; $display("[TB] FAIL basic_busy_done_overlap: got %0d expected 0", ov); end
        n_checks++;
        if (product !== 32'h0000_000F) begin n_fail++; $display("[TB] FAIL basic_product: got %h expected 0000000f", product); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_width: got %b expected 0", done); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (product !== 32'h0000_000F) begin n_fail++; $display("[TB] FAIL basic_product_hold: got %h expected 0000000f", product); end
    endtask

    task automatic test_unsigned;
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [31:0] vp [4];
        int cyc, bc, ov;
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vp[0] = 32'hFFFE_0001;
        va[1] = 16'h1234; vb[1] = 16'h5678; vp[1] = 32'h0626_0060;
        va[2] = 16'h0000; vb[2] = 16'hABCD; vp[2] = 32'h0000_0000;
        va[3] = 16'hFFFF; vb[3] = 16'h0001; vp[3] = 32'h0000_FFFF;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            wait_done(cyc, bc, ov);
            n_checks++;
            if (product !== vp[i] || cyc !== 16) begin
                n_fail++;
                $display("[TB] FAIL unsigned_%0d: got %h after %0d cycles expected %h after 16", i, product, cyc, vp[i]);
            end
            @(negedge clk);
        end
    endtask

`ifdef MUL_SEQ_SIGNED_EN
    task automatic test_signed;
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vs [5];
        logic [31:0] vp [5];
        int cyc, bc, ov;
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vs[0] = 1'b1; vp[0] = 32'h0000_0001;
        va[1] = 16'h8000; vb[1] = 16'h8000; vs[1] = 1'b1; vp[1] = 32'h4000_0000;
        va[2] = 16'h8000; vb[2] = 16'h0002; vs[2] = 1'b1; vp[2] = 32'hFFFF_0000;
        va[3] = 16'h0007; vb[3] = 16'hFFFD; vs[3] = 1'b1; vp[3] = 32'hFFFF_FFEB;
        va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vs[4] = 1'b0; vp[4] = 32'hFFFE_0001;
        for (int i = 0; i < 5; i++) begin
            sign_op = vs[i];
            start_op(va[i], vb[i]);
            sign_op = 1'b0;
            wait_done(cyc, bc, ov);
            n_checks++;
            if (product !== vp[i] || cyc !== 16) begin
                n_fail++;
                $display("[TB] FAIL signed_%0d: got %h after %0d cycles expected %h after 16", i, product, cyc, vp[i]);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_start_in_run;
        int dones;
        logic [31:0] seen;
        dones = 0;
        seen  = 32'hDEAD_BEEF;
        start_op(16'h0003, 16'h0005);
        repeat (4) @(negedge clk);
        start_op(16'h0009, 16'h0009);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                dones++;
                seen = product;
            end
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("[TB] FAIL run_start_done_count: got %0d expected 1", dones); end
        n_checks++;
        if (seen !== 32'h0000_000F) begin n_fail++; $display("[TB] FAIL run_start_product: got %h expected 0000000f", seen); end
    endtask

    task automatic test_back_to_back;
        int cyc, bc, ov;
        start_op(16'h0003, 16'h0005);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
        start_op(16'h0010, 16'h0010);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        n_checks++;
        if (product !== 32'h0000_000F) begin n_fail++; $display("[TB] FAIL b2b_product_hold: got %h expected 0000000f", product); end
        wait_done(cyc, bc, ov);
        n_checks++;
        if (product !== 32'h0000_0100 || cyc !== 16) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got %h after %0d cycles expected 00000100 after 16", product, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int dones, cyc, bc, ov;
        dones = 0;
        start_op(16'h00FF, 16'h0101);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        n_checks++;
        if (product !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_product: got %h expected 00000000", product); end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones); end
        start_op(16'h0002, 16'h0003);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (product !== 32'h0000_0006 || cyc !== 16) begin
            n_fail++;
            $display("[TB] FAIL midreset_fresh: got %h after %0d cycles expected 00000006 after 16", product, cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_unsigned();
`ifdef MUL_SEQ_SIGNED_EN
        test_signed();
`endif
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
